// File: rtl/cache_alloc_pkg.sv
// ============================================================================
// Module   : cache_alloc_pkg
// Purpose  : Shared FSM state type and helpers for the victim allocation logic
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_alloc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL_REQ  = 3'd3,
        ST_FILL_WAIT = 3'd4,
        ST_UPDATE    = 3'd5
    } alloc_state_t;

    localparam int c_max_ways = 16;

    function automatic int way_bits_for(input int ways);
        return (ways <= 2) ? 1 : $clog2(ways);
    endfunction

    // Lowest-numbered zero bit among the low 'width' bits, or -1 if none.
    function automatic int first_zero(input logic [c_max_ways-1:0] vec, input int width);
        int pos;
        pos = -1;
        for (int i = c_max_ways - 1; i >= 0; i--) begin
            if ((i < width) && !vec[i]) begin
                pos = i;
            end
        end
        return pos;
    endfunction

endpackage

`default_nettype wire

// File: rtl/first_zero_enc.sv
// ============================================================================
// Module   : first_zero_enc
// Purpose  : Priority encoder returning the lowest-numbered cleared bit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module first_zero_enc
    import cache_alloc_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int OUT_BITS = 2
) (
    input  logic [WIDTH-1:0]    i_vec,
    output logic [OUT_BITS-1:0] o_idx,
    output logic                o_found
);

    int w_pos;

    always_comb begin
        w_pos   = first_zero(c_max_ways'(i_vec), WIDTH);
        o_found = (w_pos >= 0);
        o_idx   = o_found ? OUT_BITS'(w_pos) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/victim_alloc_ctrl.sv
// ============================================================================
// Module   : victim_alloc_ctrl
// Purpose  : Cache miss victim selection, dirty writeback, refill and LRU update.
//            Optional macro VICTIM_INVALID_FIRST_EN prefers an invalid way.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module victim_alloc_ctrl
    import cache_alloc_pkg::*;
#(
    parameter int ASSOCIATIVITY = 4,
    parameter int ENTRIES       = 256,
    parameter int INDEX_BITS    = 8,
    parameter int WAY_BITS      = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     miss_valid,
    output logic                     miss_ready,
    input  logic [INDEX_BITS-1:0]    miss_index,
    input  logic                     hit_valid,
    output logic                     hit_ready,
    input  logic [INDEX_BITS-1:0]    hit_index,
    input  logic [WAY_BITS-1:0]      hit_way,
    output logic [INDEX_BITS-1:0]    line_selector,
    input  logic [WAY_BITS-1:0]      lru_way,
    output logic                     lru_update,
    output logic [WAY_BITS-1:0]      referenced_set,
    input  logic [ASSOCIATIVITY-1:0] way_valid,
    input  logic [ASSOCIATIVITY-1:0] way_dirty,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [WAY_BITS-1:0]      wb_way,
    output logic                     fill_req_valid,
    input  logic                     fill_req_ready,
    input  logic                     fill_resp_valid,
    output logic                     done_valid,
    output logic [WAY_BITS-1:0]      done_way,
    output logic [INDEX_BITS-1:0]    done_index
);

    alloc_state_t          r_state;
    logic [INDEX_BITS-1:0] r_index;
    logic [WAY_BITS-1:0]   r_victim;
    logic [WAY_BITS-1:0]   w_victim_sel;
    logic                  w_victim_dirty;
    logic                  w_hit_accept;

    generate
        if ((ASSOCIATIVITY < 2) || (ASSOCIATIVITY > c_max_ways) ||
            (WAY_BITS != way_bits_for(ASSOCIATIVITY)) ||
            (ENTRIES > (1 << INDEX_BITS))) begin : g_bad_cfg
            $error("victim_alloc_ctrl: inconsistent parameter set");
        end
    endgenerate

`ifdef VICTIM_INVALID_FIRST_EN
    logic [WAY_BITS-1:0] w_free_way;
    logic                w_free_found;

    first_zero_enc #(
        .WIDTH    (ASSOCIATIVITY),
        .OUT_BITS (WAY_BITS)
    ) u_first_zero (
        .i_vec   (way_valid),
        .o_idx   (w_free_way),
        .o_found (w_free_found)
    );

    assign w_victim_sel = w_free_found ? w_free_way : lru_way;
`else
    assign w_victim_sel = lru_way;
`endif

    // Only a line that is both valid and dirty carries data worth saving.
    assign w_victim_dirty = way_valid[w_victim_sel] & way_dirty[w_victim_sel];

    assign miss_ready     = (r_state == ST_IDLE);
    assign hit_ready      = (r_state != ST_SELECT) && (r_state != ST_UPDATE);
    assign w_hit_accept   = hit_valid & hit_ready;
    assign wb_valid       = (r_state == ST_WRITEBACK);
    assign wb_way         = r_victim;
    assign fill_req_valid = (r_state == ST_FILL_REQ);
    assign done_valid     = (r_state == ST_UPDATE);
    assign done_way       = r_victim;
    assign done_index     = r_index;

    // The LRU port is shared: UPDATE owns it, otherwise an accepted hit does.
    always_comb begin
        line_selector  = r_index;
        referenced_set = r_victim;
        lru_update     = 1'b0;
        if (r_state == ST_UPDATE) begin
            lru_update = 1'b1;
        end else if (w_hit_accept) begin
            lru_update     = 1'b1;
            referenced_set = hit_way;
            line_selector  = hit_index;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_index  <= '0;
            r_victim <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (miss_valid) begin
                        r_index <= miss_index;
                        r_state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    r_victim <= w_victim_sel;
                    r_state  <= w_victim_dirty ? ST_WRITEBACK : ST_FILL_REQ;
                end
                ST_WRITEBACK: begin
                    if (wb_ready) begin
                        r_state <= ST_FILL_REQ;
                    end
                end
                ST_FILL_REQ: begin
                    if (fill_req_ready) begin
                        r_state <= ST_FILL_WAIT;
                    end
                end
                ST_FILL_WAIT: begin
                    if (fill_resp_valid) begin
                        r_state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_victim_alloc_ctrl.sv
// ============================================================================
// Module   : tb_victim_alloc_ctrl
// Purpose  : Table-driven, scoreboard-checked bench for victim_alloc_ctrl
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_victim_alloc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       miss_valid, miss_ready;
    logic [7:0] miss_index;
    logic       hit_valid, hit_ready;
    logic [7:0] hit_index;
    logic [1:0] hit_way;
    logic [7:0] line_selector;
    logic [1:0] lru_way;
    logic       lru_update;
    logic [1:0] referenced_set;
    logic [3:0] way_valid, way_dirty;
    logic       wb_valid, wb_ready;
    logic [1:0] wb_way;
    logic       fill_req_valid, fill_req_ready, fill_resp_valid;
    logic       done_valid;
    logic [1:0] done_way;
    logic [7:0] done_index;

    int n_checks = 0;
    int n_err    = 0;

    victim_alloc_ctrl #(
        .ASSOCIATIVITY (4),
        .ENTRIES       (256),
        .INDEX_BITS    (8),
        .WAY_BITS      (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .miss_valid      (miss_valid),
        .miss_ready      (miss_ready),
        .miss_index      (miss_index),
        .hit_valid       (hit_valid),
        .hit_ready       (hit_ready),
        .hit_index       (hit_index),
        .hit_way         (hit_way),
        .line_selector   (line_selector),
        .lru_way         (lru_way),
        .lru_update      (lru_update),
        .referenced_set  (referenced_set),
        .way_valid       (way_valid),
        .way_dirty       (way_dirty),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_way          (wb_way),
        .fill_req_valid  (fill_req_valid),
        .fill_req_ready  (fill_req_ready),
        .fill_resp_valid (fill_resp_valid),
        .done_valid      (done_valid),
        .done_way        (done_way),
        .done_index      (done_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] idx;
        logic [1:0] lru;
        logic [3:0] valid;
        logic [3:0] dirty;
        int         wb_dly;
        int         fill_dly;
        int         resp_dly;
        bit         do_hit;
        logic [1:0] exp_way;
        bit         exp_wb;
    } vec_t;

    typedef struct packed {
        logic [7:0] idx;
        logic [1:0] way;
    } done_t;

    done_t sb_q[$];
    done_t sb_e;
    vec_t  tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] idx, input logic [1:0] lru,
                                input logic [3:0] valid, input logic [3:0] dirty,
                                input int wb_dly, input int fill_dly, input int resp_dly,
                                input bit do_hit, input logic [1:0] exp_way, input bit exp_wb);
        vec_t v;
        v.idx = idx; v.lru = lru; v.valid = valid; v.dirty = dirty;
        v.wb_dly = wb_dly; v.fill_dly = fill_dly; v.resp_dly = resp_dly;
        v.do_hit = do_hit; v.exp_way = exp_way; v.exp_wb = exp_wb;
        return v;
    endfunction

    // Completion monitor: every done pulse must match the oldest accepted miss.
    always @(negedge clk) begin
        if (rst_n && done_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL done_unexpected: got done_valid=1 way=%0d index=%0h expected no pulse", done_way, done_index);
            end else begin
                sb_e = sb_q.pop_front();
                check("done_way", 32'(done_way), 32'(sb_e.way));
                check("done_index", 32'(done_index), 32'(sb_e.idx));
            end
        end
    end

    task automatic run_miss(input vec_t v);
        int guard;
        guard = 0;
        while (!miss_ready && guard < 50) begin
            step();
            guard++;
        end
        check("miss_ready_idle", 32'(miss_ready), 32'd1);
        miss_valid = 1'b1;
        miss_index = v.idx;
        lru_way    = v.lru;
        way_valid  = v.valid;
        way_dirty  = v.dirty;
        sb_q.push_back('{idx: v.idx, way: v.exp_way});
        step();
        miss_valid = 1'b0;
        miss_index = 8'h00;
        check("sel_line", 32'(line_selector), 32'(v.idx));
        check("sel_miss_ready", 32'(miss_ready), 32'd0);
        check("sel_hit_ready", 32'(hit_ready), 32'd0);
        step();
        if (v.exp_wb) begin
            for (int k = 0; k < v.wb_dly; k++) begin
                check("wb_valid_hold", 32'(wb_valid), 32'd1);
                check("wb_way_hold", 32'(wb_way), 32'(v.exp_way));
                check("wb_no_fill", 32'(fill_req_valid), 32'd0);
                step();
            end
            wb_ready = 1'b1;
            check("wb_valid_xfer", 32'(wb_valid), 32'd1);
            check("wb_way_xfer", 32'(wb_way), 32'(v.exp_way));
            step();
            wb_ready = 1'b0;
        end
        check("no_wb", 32'(wb_valid), 32'd0);
        for (int k = 0; k < v.fill_dly; k++) begin
            check("fill_req_hold", 32'(fill_req_valid), 32'd1);
            step();
        end
        fill_req_ready = 1'b1;
        check("fill_req_xfer", 32'(fill_req_valid), 32'd1);
        step();
        fill_req_ready = 1'b0;
        check("fill_wait_req_low", 32'(fill_req_valid), 32'd0);
        if (v.do_hit) begin
            hit_valid = 1'b1; hit_index = 8'h05; hit_way = 2'd3;
            #1;
            check("hit_wait_ready", 32'(hit_ready), 32'd1);
            check("hit_wait_update", 32'(lru_update), 32'd1);
            check("hit_wait_ref", 32'(referenced_set), 32'd3);
            check("hit_wait_line", 32'(line_selector), 32'h05);
            hit_valid = 1'b0;
            #1;
            check("hit_wait_released", 32'(lru_update), 32'd0);
        end
        for (int k = 0; k < v.resp_dly; k++) begin
            check("wait_no_done", 32'(done_valid), 32'd0);
            step();
        end
        fill_resp_valid = 1'b1;
        step();
        fill_resp_valid = 1'b0;
        if (v.do_hit) begin
            hit_valid = 1'b1; hit_index = 8'h05; hit_way = 2'd3;
            #1;
            check("hit_upd_ready", 32'(hit_ready), 32'd0);
        end
        check("upd_done", 32'(done_valid), 32'd1);
        check("upd_lru_update", 32'(lru_update), 32'd1);
        check("upd_ref", 32'(referenced_set), 32'(v.exp_way));
        check("upd_line", 32'(line_selector), 32'(v.idx));
        step();
        check("idle_miss_ready", 32'(miss_ready), 32'd1);
        check("idle_done_low", 32'(done_valid), 32'd0);
        if (v.do_hit) begin
            check("hit_late_update", 32'(lru_update), 32'd1);
            check("hit_late_ref", 32'(referenced_set), 32'd3);
            check("hit_late_line", 32'(line_selector), 32'h05);
            hit_valid = 1'b0;
            #1;
        end
        check("idle_lru_low", 32'(lru_update), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        miss_valid = 1'b0; miss_index = '0;
        hit_valid = 1'b0; hit_index = '0; hit_way = '0;
        lru_way = '0; way_valid = 4'hF; way_dirty = 4'h0;
        wb_ready = 1'b0; fill_req_ready = 1'b0; fill_resp_valid = 1'b0;

        //            idx    lru   valid    dirty    wb fl rs hit  way  wb
        tbl[0] = mk(8'h12, 2'd2, 4'b1111, 4'b0000, 0, 0, 0, 0, 2'd2, 1'b0);
        tbl[1] = mk(8'h34, 2'd1, 4'b1111, 4'b0010, 3, 0, 0, 0, 2'd1, 1'b1);
`ifdef VICTIM_INVALID_FIRST_EN
        tbl[2] = mk(8'h56, 2'd0, 4'b1011, 4'b0000, 0, 0, 0, 0, 2'd2, 1'b0);
        tbl[4] = mk(8'hFF, 2'd1, 4'b0111, 4'b1010, 1, 0, 1, 0, 2'd3, 1'b0);
        tbl[5] = mk(8'h00, 2'd2, 4'b0000, 4'b1111, 0, 1, 0, 0, 2'd0, 1'b0);
`else
        tbl[2] = mk(8'h56, 2'd0, 4'b1011, 4'b0000, 0, 0, 0, 0, 2'd0, 1'b0);
        tbl[4] = mk(8'hFF, 2'd1, 4'b0111, 4'b1010, 1, 0, 1, 0, 2'd1, 1'b1);
        tbl[5] = mk(8'h00, 2'd2, 4'b0000, 4'b1111, 0, 1, 0, 0, 2'd2, 1'b0);
`endif
        tbl[3] = mk(8'h78, 2'd3, 4'b1111, 4'b1000, 0, 2, 3, 1, 2'd3, 1'b1);

        step();
        step();
        check("rst_miss_ready", 32'(miss_ready), 32'd1);
        check("rst_hit_ready", 32'(hit_ready), 32'd1);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_fill_req", 32'(fill_req_valid), 32'd0);
        check("rst_done", 32'(done_valid), 32'd0);
        check("rst_lru_update", 32'(lru_update), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_miss_ready", 32'(miss_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_miss(tbl[i]);
        end

        // Reset while waiting for refill data abandons the miss silently.
        miss_valid = 1'b1; miss_index = 8'h9A; lru_way = 2'd1;
        way_valid = 4'hF; way_dirty = 4'h0; fill_req_ready = 1'b1;
        step();
        miss_valid = 1'b0;
        step();
        step();
        fill_req_ready = 1'b0;
        check("abort_in_wait", 32'(miss_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_async_idle", 32'(miss_ready), 32'd1);
        check("abort_done_low", 32'(done_valid), 32'd0);
        step();
        rst_n = 1'b1;
        fill_resp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("abort_no_done", 32'(done_valid), 32'd0);
            check("abort_no_lru", 32'(lru_update), 32'd0);
            check("abort_miss_ready", 32'(miss_ready), 32'd1);
        end
        fill_resp_valid = 1'b0;

        // Back-to-back: second miss held valid, accepted only after done.
        wb_ready = 1'b1; fill_req_ready = 1'b1; fill_resp_valid = 1'b1;
        lru_way = 2'd1; way_valid = 4'hF; way_dirty = 4'h0;
        miss_valid = 1'b1; miss_index = 8'hA0;
        sb_q.push_back('{idx: 8'hA0, way: 2'd1});
        step();
        miss_index = 8'hB0;
        check("b2b_sel_ready", 32'(miss_ready), 32'd0);
        step();
        check("b2b_req_ready", 32'(miss_ready), 32'd0);
        step();
        check("b2b_wait_ready", 32'(miss_ready), 32'd0);
        step();
        check("b2b_upd_done", 32'(done_valid), 32'd1);
        check("b2b_upd_ready", 32'(miss_ready), 32'd0);
        step();
        check("b2b_idle_ready", 32'(miss_ready), 32'd1);
        sb_q.push_back('{idx: 8'hB0, way: 2'd1});
        step();
        miss_valid = 1'b0;
        check("b2b_second_line", 32'(line_selector), 32'hB0);
        check("b2b_second_busy", 32'(miss_ready), 32'd0);
        step();
        step();
        step();
        check("b2b_second_done", 32'(done_valid), 32'd1);
        step();
        wb_ready = 1'b0; fill_req_ready = 1'b0; fill_resp_valid = 1'b0;
        step();

        check("scoreboard_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/victim_alloc_ctrl.md
VICTIM_ALLOC_CTRL -- requirements
Module: victim_alloc_ctrl

Interface
REQ-001 SHALL have parameter ASSOCIATIVITY, 4, ways per set (4/8/16).
REQ-002 SHALL have parameter ENTRIES, 256, sets addressed.
REQ-003 SHALL have parameter INDEX_BITS, 8, set index width.
REQ-004 SHALL have parameter WAY_BITS, 2, log2(ASSOCIATIVITY).
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports miss_valid/miss_ready  in/out  1/1  miss request handshake; miss_index  in  INDEX_BITS.
REQ-008 SHALL have ports hit_valid/hit_ready  in/out  1/1, hit_index  in  INDEX_BITS, hit_way  in  WAY_BITS  hit notification.
REQ-009 SHALL have ports line_selector  out  INDEX_BITS, lru_way  in  WAY_BITS, lru_update  out  1, referenced_set  out  WAY_BITS  (LRU read/update port).
REQ-010 SHALL have ports way_valid, way_dirty  in  ASSOCIATIVITY  tag-array status of the set on line_selector.
REQ-011 SHALL have ports wb_valid/wb_ready  out/in  1/1, wb_way  out  WAY_BITS  dirty writeback handshake.
REQ-012 SHALL have ports fill_req_valid/fill_req_ready  out/in  1/1, fill_resp_valid  in  1  memory refill.
REQ-013 SHALL have ports done_valid  out  1, done_way  out  WAY_BITS, done_index  out  INDEX_BITS  one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM IDLE, SELECT, WRITEBACK, FILL_REQ, FILL_WAIT, UPDATE.
REQ-015 IDLE: miss_ready=1; miss_valid&miss_ready latches miss_index -> SELECT.
REQ-016 SELECT (one cycle): line_selector=latched index; victim=lru_way (or per REQ-027) registered; dirty&valid victim -> WRITEBACK, else FILL_REQ.
REQ-017 WRITEBACK: wb_valid=1, wb_way=victim stable until wb_ready; transfer -> FILL_REQ.
REQ-018 FILL_REQ: fill_req_valid=1 until fill_req_ready -> FILL_WAIT.
REQ-019 FILL_WAIT: fill_resp_valid -> UPDATE; waits indefinitely.
REQ-020 UPDATE (one cycle): lru_update=1, referenced_set=victim, line_selector=latched index, done_valid=1 with done_way/done_index; next state IDLE.
REQ-021 Miss-to-done latency SHALL be 4 cycles with wb_ready, fill_req_ready, fill_resp_valid asserted in the earliest cycle, no writeback.
REQ-022 hit_ready=1 in all states except SELECT and UPDATE; accepted hit drives lru_update=1, referenced_set=hit_way, line_selector=hit_index in the same cycle (combinational).
REQ-023 Hit with hit_index equal to an in-flight miss index SHALL still update; UPDATE state overrides afterwards.
REQ-024 miss_ready=0 outside IDLE; only one miss outstanding.
REQ-025 Outputs wb_valid, fill_req_valid, done_valid, lru_update SHALL never assert outside their states/REQ-022.

Reset
REQ-026 rst_n low SHALL force IDLE, clear latched index/victim, all valid/update outputs 0, miss_ready 1 after release; reset mid-operation abandons the miss with no done pulse.

Configuration
REQ-027 Macro VICTIM_INVALID_FIRST_EN: defined -> SELECT picks lowest-numbered way with way_valid=0, falling back to lru_way when all valid; undefined -> always lru_way.

Structure
REQ-028 State enum, WAY_BITS derivation and priority-encoder function SHALL live in shared package cache_alloc_pkg.
REQ-029 Invalid-way priority encoder SHALL be sub-module first_zero_enc (WAY_BITS output, found flag).

Verification
REQ-030 Reset, single miss index 0x12, lru_way=2, clean -> done_valid at cycle 4, done_way=2, lru_update with referenced_set=2.
REQ-031 Miss, victim 1 dirty, wb_ready delayed 3 cycles -> wb_valid held 3 cycles with wb_way=1, then fill_req_valid.
REQ-032 Macro defined, way_valid=4'b1011, lru_way=0 -> victim 2; macro undefined -> victim 0.
REQ-033 Hit (index 5, way 3) during FILL_WAIT -> immediate lru_update, referenced_set=3; hit during UPDATE -> hit_ready=0, accepted next cycle.
REQ-034 rst_n pulsed in FILL_WAIT -> IDLE, no done_valid, miss_ready=1 after release.
REQ-035 Back-to-back misses -> second accepted only in cycle after done_valid.
